// File: rtl/dlbf_coeffs_pkg.sv
// dlbf_coeffs_pkg: shared defaults, FSM state encodings and the FIFO entry layout for the coeffs reader.
package dlbf_coeffs_pkg;
   localparam int DEF_DATA_WIDTH   = 128;
   localparam int DEF_ADDR_WIDTH   = 16;
   localparam int DEF_CNT_WIDTH    = 12;
   localparam int DEF_BRAM_LATENCY = 2;
   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_RUN   = 2'd1;
   localparam state_t ST_DRAIN = 2'd2;
   localparam state_t ST_DONE  = 2'd3;
   typedef struct packed {
      logic                      last;
      logic [DEF_DATA_WIDTH-1:0] data;
   } coeff_entry_t;
endpackage

// File: rtl/dlbf_coeffs_skid_fifo.sv
// dlbf_coeffs_skid_fifo: {tlast,tdata} FIFO feeding a registered AXIS output; an empty FIFO is bypassed.
module dlbf_coeffs_skid_fifo #(
   parameter int WIDTH = 129,
   parameter int DEPTH = 4,
   localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1,
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   output logic [CW-1:0]    count,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready
);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic out_valid_q, out_valid_d, out_free, pop, bypass, push;

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return p == PW'(DEPTH - 1) ? '0 : p + PW'(1);
   endfunction

   always_comb begin
      out_free = ~out_valid_q | out_ready;
      pop = out_free & count_q != '0;
      bypass = out_free & count_q == '0 & wr_en;
      push = wr_en & ~bypass & ~flush;
      rd_ptr_d = pop ? nxt(rd_ptr_q) : rd_ptr_q;
      wr_ptr_d = push ? nxt(wr_ptr_q) : wr_ptr_q;
      count_d = count_q + CW'(push) - CW'(pop);
      out_valid_d = ~out_free | pop | bypass;
      out_data_d = pop ? mem_q[rd_ptr_q] : bypass ? wr_data : out_data_q;
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d = '0;
         out_valid_d = 1'b0;
         out_data_d = '0;
      end
   end

   always_ff @(posedge clk)
      if (push) mem_q[wr_ptr_q] <= wr_data;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q <= '0;
         out_valid_q <= 1'b0;
         out_data_q <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q <= count_d;
         out_valid_q <= out_valid_d;
         out_data_q <= out_data_d;
      end

   assign count = count_q;
   assign out_data = out_data_q;
   assign out_valid = out_valid_q;
endmodule

// File: rtl/dlbf_coeffs_maxis_reader.sv
// dlbf_coeffs_maxis_reader: reads coefficient words from BRAM port B and streams them on AXI4-Stream.
// Define DLBF_COEFFS_BEAT_CNT_EN to add the saturating beat_count output.
module dlbf_coeffs_maxis_reader
   import dlbf_coeffs_pkg::*;
#(
   parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
   parameter int CNT_WIDTH    = DEF_CNT_WIDTH,
   parameter int BRAM_LATENCY = DEF_BRAM_LATENCY,
   parameter int FIFO_DEPTH   = 4
) (
`ifdef DLBF_COEFFS_BEAT_CNT_EN
   output logic [31:0]           beat_count,
`endif
   input  logic                  m_axis_clk,
   input  logic                  m_axis_rst_n,
   input  logic                  soft_rst,
   input  logic                  go,
   input  logic [CNT_WIDTH-1:0]  niter,
   input  logic [CNT_WIDTH-1:0]  block_size,
   input  logic [ADDR_WIDTH-1:0] rollover_addr,
   output logic                  enb,
   output logic [ADDR_WIDTH-1:0] addrb,
   input  logic [DATA_WIDTH-1:0] doutb,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tlast,
   output logic                  done
);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int OW = $clog2(FIFO_DEPTH + BRAM_LATENCY + 2) + 1;

   state_t state_q, state_d;
   logic go_q, done_q, done_d;
   logic [CNT_WIDTH-1:0] niter_q, niter_d, bs_q, bs_d, word_q, word_d, iter_q, iter_d, word, iter;
   logic [ADDR_WIDTH-1:0] roll_q, roll_d, rd_addr_q, rd_addr_d, addrb_q, addrb_d, rd_addr;
   logic [BRAM_LATENCY:0] vld_q, vld_d, tag_q, tag_d;
   logic [CW-1:0] fifo_count;
   logic [OW-1:0] inflight;
   logic [DATA_WIDTH:0] out_word;
   logic start, zero, issue, blk_end, run_end, drain_exit;

   always_comb begin
      start = go & ~go_q & (state_q == ST_IDLE | state_q == ST_DONE);
      zero = niter == '0 | block_size == '0;
      niter_d = start ? niter : niter_q;
      bs_d = start ? block_size : bs_q;
      roll_d = start ? rollover_addr : roll_q;
      word = start ? '0 : word_q;
      iter = start ? '0 : iter_q;
      rd_addr = start ? '0 : rd_addr_q;
      inflight = '0;
      for (int i = 0; i <= BRAM_LATENCY; i++) inflight = inflight + OW'(vld_q[i]);
      // Credit: every read in flight already owns a FIFO slot, so back-pressure can never overflow it.
      issue = (state_q == ST_RUN | start & ~zero) & (OW'(fifo_count) + inflight < OW'(FIFO_DEPTH));
      blk_end = word == bs_d - CNT_WIDTH'(1);
      run_end = blk_end & iter == niter_d - CNT_WIDTH'(1);
      drain_exit = state_q == ST_DRAIN & inflight == '0 & fifo_count == '0 & (~m_axis_tvalid | m_axis_tready);
      state_d = start & zero ? ST_DONE : issue & run_end ? ST_DRAIN : start ? ST_RUN : drain_exit ? ST_DONE : state_q;
      rd_addr_d = issue ? (rd_addr == roll_d ? '0 : rd_addr + ADDR_WIDTH'(1)) : rd_addr;
      word_d = issue ? (blk_end ? '0 : word + CNT_WIDTH'(1)) : word;
      iter_d = issue & blk_end ? iter + CNT_WIDTH'(1) : iter;
      addrb_d = issue ? rd_addr : addrb_q;
      vld_d = {vld_q[BRAM_LATENCY-1:0], issue};
      tag_d = {tag_q[BRAM_LATENCY-1:0], issue & blk_end};
      done_d = ~start & (state_q == ST_DONE | drain_exit);
      if (soft_rst) begin
         state_d = ST_IDLE;
         addrb_d = '0;
         done_d = 1'b0;
         vld_d = '0;
      end
   end

   always_ff @(posedge m_axis_clk or negedge m_axis_rst_n)
      if (!m_axis_rst_n) begin
         state_q <= ST_IDLE;
         go_q <= 1'b0;
         done_q <= 1'b0;
         niter_q <= '0;
         bs_q <= '0;
         roll_q <= '0;
         word_q <= '0;
         iter_q <= '0;
         rd_addr_q <= '0;
         addrb_q <= '0;
         vld_q <= '0;
         tag_q <= '0;
      end else begin
         state_q <= state_d;
         go_q <= go;
         done_q <= done_d;
         niter_q <= niter_d;
         bs_q <= bs_d;
         roll_q <= roll_d;
         word_q <= word_d;
         iter_q <= iter_d;
         rd_addr_q <= rd_addr_d;
         addrb_q <= addrb_d;
         vld_q <= vld_d;
         tag_q <= tag_d;
      end

   dlbf_coeffs_skid_fifo #(.WIDTH(DATA_WIDTH + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(m_axis_clk),
      .rst_n(m_axis_rst_n),
      .flush(soft_rst),
      .wr_en(vld_q[BRAM_LATENCY]),
      .wr_data({tag_q[BRAM_LATENCY], doutb}),
      .count(fifo_count),
      .out_data(out_word),
      .out_valid(m_axis_tvalid),
      .out_ready(m_axis_tready)
   );

   assign {m_axis_tlast, m_axis_tdata} = out_word;
   assign enb = vld_q[0];
   assign addrb = addrb_q;
   assign done = done_q;

`ifdef DLBF_COEFFS_BEAT_CNT_EN
   logic [31:0] beat_q, beat_d;
   always_comb
      beat_d = soft_rst | start ? '0 : m_axis_tvalid & m_axis_tready & ~&beat_q ? beat_q + 32'd1 : beat_q;
   always_ff @(posedge m_axis_clk or negedge m_axis_rst_n)
      if (!m_axis_rst_n) beat_q <= '0;
      else beat_q <= beat_d;
   assign beat_count = beat_q;
`endif
endmodule

// File: tb/tb_dlbf_coeffs_maxis_reader.sv
// tb_dlbf_coeffs_maxis_reader: scoreboard bench; expected addresses and beats are queued, a monitor pops them.
module tb_dlbf_coeffs_maxis_reader;
   import dlbf_coeffs_pkg::*;

   logic clk = 0, rst_n = 0, soft_rst = 0, go = 0, m_axis_tready = 1;
   logic [11:0] niter = 0, block_size = 0;
   logic [15:0] rollover_addr = 0, addrb;
   logic [127:0] doutb = 0, r1 = 0, m_axis_tdata;
   logic enb, m_axis_tvalid, m_axis_tlast, done;
`ifdef DLBF_COEFFS_BEAT_CNT_EN
   logic [31:0] beat_count;
`endif

   int tests = 0, failed = 0, cyc = 0, tr_mode = 0;
   int first_enb = -1, first_vld = -1, done_cyc = -1, last_beat = -1, beats = 0, enb_seen = 0, go_cyc = 0;
   logic prev_done = 0, prev_stall = 0;
   logic [128:0] prev_word = 0;
   logic [15:0] exp_addr[$];
   coeff_entry_t exp_q[$];

   dlbf_coeffs_maxis_reader dut (
`ifdef DLBF_COEFFS_BEAT_CNT_EN
      .beat_count(beat_count),
`endif
      .m_axis_clk(clk), .m_axis_rst_n(rst_n), .soft_rst(soft_rst), .go(go),
      .niter(niter), .block_size(block_size), .rollover_addr(rollover_addr),
      .enb(enb), .addrb(addrb), .doutb(doutb),
      .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
      .m_axis_tlast(m_axis_tlast), .done(done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [127:0] mem_word(input logic [15:0] a);
      return {8{a ^ 16'h5A3C}};
   endfunction

   // Two-cycle BRAM: address sampled on one edge, data presented after the next.
   always @(posedge clk) begin
      if (enb) r1 <= mem_word(addrb);
      doutb <= r1;
   end

   task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic fail(input string nm, input logic [159:0] act);
      tests++;
      failed++;
      $display("FAIL %s: got %0h with nothing expected", nm, act);
   endtask

   initial forever begin
      @(posedge clk);
      #1 m_axis_tready = tr_mode == 0 ? 1'b1 : tr_mode == 1 ? 1'($urandom_range(0, 1)) : 1'b0;
   end

   always @(negedge clk) if (rst_n) begin
      if (enb) begin
         enb_seen++;
         if (first_enb < 0) first_enb = cyc;
         if (exp_addr.size() == 0) fail("enb_unexpected", 160'(addrb));
         else chk("addrb", 160'(addrb), 160'(exp_addr.pop_front()));
      end
      if (m_axis_tvalid && first_vld < 0) first_vld = cyc;
      if (prev_stall) chk("stall_hold", 160'({m_axis_tvalid, m_axis_tlast, m_axis_tdata}), 160'({1'b1, prev_word}));
      if (m_axis_tvalid && m_axis_tready) begin
         beats++;
         last_beat = cyc;
         if (exp_q.size() == 0) fail("beat_unexpected", 160'({m_axis_tlast, m_axis_tdata}));
         else chk("beat", 160'({m_axis_tlast, m_axis_tdata}), 160'(exp_q.pop_front()));
      end
      if (done && !prev_done) done_cyc = cyc;
      prev_done = done;
      prev_stall = m_axis_tvalid & ~m_axis_tready & ~soft_rst;
      prev_word = {m_axis_tlast, m_axis_tdata};
   end

   task automatic expect_run(input int ni, input int bs, input int roll);
      int a = 0;
      for (int it = 0; it < ni; it++)
         for (int w = 0; w < bs; w++) begin
            exp_addr.push_back(16'(a));
            exp_q.push_back({1'(w == bs - 1), mem_word(16'(a))});
            a = (a == roll) ? 0 : a + 1;
         end
   endtask

   task automatic run(input int ni, input int bs, input int roll, input int mode, input bit repulse);
      expect_run(ni, bs, roll);
      tr_mode = mode;
      @(posedge clk);
      #1;
      first_enb = -1; first_vld = -1; done_cyc = -1; last_beat = -1; beats = 0; enb_seen = 0;
      niter = 12'(ni); block_size = 12'(bs); rollover_addr = 16'(roll); go = 1; go_cyc = cyc;
      if (repulse) begin
         repeat (3) @(posedge clk);
         #1 go = 0;
         @(posedge clk);
         #1 go = 1;
      end
      for (int i = 0; i < 400 && done_cyc < 0; i++) @(negedge clk);
      if (done_cyc < 0) fail("done_timeout", 160'(beats));
      chk("beat_total", 160'(beats), 160'(ni * bs));
      chk("beats_left", 160'(exp_q.size()), 160'(0));
      chk("addrs_left", 160'(exp_addr.size()), 160'(0));
      if (ni * bs == 0) begin
         chk("zero_done_lat", 160'(done_cyc - go_cyc), 160'(2));
         chk("zero_no_enb", 160'(enb_seen), 160'(0));
         chk("zero_no_tvalid", 160'(first_vld), 160'(-1));
      end else begin
         chk("enb_lat", 160'(first_enb - go_cyc), 160'(1));
         chk("tvalid_lat", 160'(first_vld - go_cyc), 160'(4));
         chk("done_after_last", 160'(done_cyc - last_beat), 160'(1));
      end
`ifdef DLBF_COEFFS_BEAT_CNT_EN
      chk("beat_count", 160'(beat_count), 160'(ni * bs));
`endif
      @(posedge clk);
      #1 go = 0;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_enb", 160'(enb), 160'(0));
      chk("rst_addrb", 160'(addrb), 160'(0));
      chk("rst_tvalid", 160'(m_axis_tvalid), 160'(0));
      chk("rst_tlast", 160'(m_axis_tlast), 160'(0));
      chk("rst_tdata", 160'(m_axis_tdata), 160'(0));
      chk("rst_done", 160'(done), 160'(0));
`ifdef DLBF_COEFFS_BEAT_CNT_EN
      chk("rst_beat_count", 160'(beat_count), 160'(0));
`endif
      rst_n = 1;
      repeat (2) @(posedge clk);
      run(2, 4, 15, 0, 0);
      run(1, 6, 3, 0, 0);
      run(3, 5, 9, 1, 0);
      run(0, 4, 15, 0, 0);
      run(3, 0, 15, 0, 0);
      // Stall the stream until the buffer is full, then flush mid-run.
      expect_run(4, 8, 31);
      tr_mode = 2;
      @(posedge clk);
      #1 niter = 4; block_size = 8; rollover_addr = 31; go = 1;
      repeat (12) @(posedge clk);
      #1 go = 0;
      chk("full_addrb", 160'(addrb), 160'(4));
      chk("full_tvalid", 160'(m_axis_tvalid), 160'(1));
      soft_rst = 1;
      exp_q.delete();
      exp_addr.delete();
      @(posedge clk);
      #1 soft_rst = 0;
      @(negedge clk);
      chk("srst_tvalid", 160'(m_axis_tvalid), 160'(0));
      chk("srst_enb", 160'(enb), 160'(0));
      chk("srst_done", 160'(done), 160'(0));
      chk("srst_addrb", 160'(addrb), 160'(0));
      run(1, 3, 15, 0, 0);
      run(2, 4, 15, 0, 1);
      repeat (5) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
